// File: rtl/popcount255_pipe.sv
// Two-stage population counter for a fixed 255-bit word: 16 chunk partials
// are registered in stage 1, then summed by an adder tree into the 8-bit result.
module popcount255_pipe (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [254:0] in,
   output logic         out_valid,
   output logic [7:0]   out
);

   function automatic logic [4:0] pop16(input logic [15:0] w);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + {4'd0, w[i]};
      end
      return c;
   endfunction

   logic [15:0] chunk_p0   [16];
   logic [4:0]  partial_p1 [16];
   logic        vld_p1;

   logic [5:0]  s1_p1 [8];
   logic [6:0]  s2_p1 [4];
   logic [7:0]  s3_p1 [2];
   logic [7:0]  sum_p1;

   // The top chunk is only 15 bits wide; pad with zero rather than reading bit 255.
   always_comb begin
      for (int k = 0; k < 15; k++) begin
         chunk_p0[k] = in[16*k +: 16];
      end
      chunk_p0[15] = {1'b0, in[254:240]};
   end

   // ---- stage 1: per-chunk partial counts ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         for (int k = 0; k < 16; k++) begin
            partial_p1[k] <= '0;
         end
      end else begin
         vld_p1 <= in_valid;
         for (int k = 0; k < 16; k++) begin
            partial_p1[k] <= pop16(chunk_p0[k]);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         s1_p1[i] = {1'b0, partial_p1[2*i]} + {1'b0, partial_p1[2*i+1]};
      end
      for (int i = 0; i < 4; i++) begin
         s2_p1[i] = {1'b0, s1_p1[2*i]} + {1'b0, s1_p1[2*i+1]};
      end
      for (int i = 0; i < 2; i++) begin
         s3_p1[i] = {1'b0, s2_p1[2*i]} + {1'b0, s2_p1[2*i+1]};
      end
      sum_p1 = s3_p1[0] + s3_p1[1];
   end

   // ---- stage 2: final sum register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
      end else begin
         out_valid <= vld_p1;
         out       <= sum_p1;
      end
   end

endmodule

// File: tb/tb_popcount255_pipe.sv
// Directed and random checks of popcount255_pipe against hand-computed counts
// carried through a two-slot expected-value delay line.
module tb_popcount255_pipe;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [254:0] din;
   logic         out_valid;
   logic [7:0]   dout;

   int checks;
   int errors;

   logic       e1v, e2v;
   logic [7:0] e1c, e2c;

   popcount255_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in       (din),
      .out_valid(out_valid),
      .out      (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle of input, advance the expected pipeline, then check outputs.
   task automatic step(input logic r, input logic v, input logic [254:0] d, input logic [7:0] cnt);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      din      = d;
      @(posedge clk);
      if (r) begin
         e1v = 1'b0; e1c = '0; e2v = 1'b0; e2c = '0;
      end else begin
         e2v = e1v; e2c = e1c;
         e1v = v;   e1c = cnt;
      end
      #1;
      check("out_valid", {7'd0, out_valid}, {7'd0, e2v});
      check("out", dout, e2c);
   endtask

   logic [254:0] ones;
   logic [254:0] w;
   logic [255:0] rnd;

   initial begin
      checks = 0; errors = 0;
      e1v = 1'b0; e2v = 1'b0; e1c = '0; e2c = '0;
      rst = 1'b1; in_valid = 1'b0; din = '0;
      ones = '1;

      // reset for two cycles
      step(1'b1, 1'b0, '0, 8'd0);
      step(1'b1, 1'b0, ones, 8'd0);

      // single words and patterns, back-to-back
      step(1'b0, 1'b1, 255'h0, 8'h00);
      step(1'b0, 1'b1, 255'h1, 8'h01);
      step(1'b0, 1'b1, 255'h3, 8'h02);
      step(1'b0, 1'b1, 255'h7, 8'h03);
      step(1'b0, 1'b1, 255'haaaa, 8'h08);
      step(1'b0, 1'b1, 255'hf0000, 8'h04);

      // extremes and chunk boundaries
      step(1'b0, 1'b1, ones, 8'hFF);
      w = '0; w[254] = 1'b1;
      step(1'b0, 1'b1, w, 8'h01);
      w = '0; w[15] = 1'b1; w[16] = 1'b1;
      step(1'b0, 1'b1, w, 8'h02);
      w = '0; w[239] = 1'b1; w[240] = 1'b1;
      step(1'b0, 1'b1, w, 8'h02);
      step(1'b0, 1'b0, '0, 8'h00);
      step(1'b0, 1'b0, '0, 8'h00);

      // valid gating: alternating strobe, count of ones>>(7i) is 255-7i
      for (int i = 0; i < 12; i++) begin
         step(1'b0, ~i[0], ones >> (7 * i), 8'(255 - 7 * i));
      end
      step(1'b0, 1'b0, '0, 8'h00);
      step(1'b0, 1'b0, '0, 8'h00);

      // reset while two words are in flight
      step(1'b0, 1'b1, 255'h1f, 8'd5);
      step(1'b0, 1'b1, 255'h3ff, 8'd10);
      step(1'b0, 1'b1, ones, 8'd255);
      step(1'b1, 1'b0, '0, 8'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, '0, 8'd0);
      end

      // random soak
      for (int i = 0; i < 1000; i++) begin
         for (int j = 0; j < 8; j++) begin
            rnd[32*j +: 32] = $urandom;
         end
         w = rnd[254:0];
         step(1'b0, 1'($urandom_range(0, 1)), w, 8'($countones(w)));
      end
      step(1'b0, 1'b0, '0, 8'h00);
      step(1'b0, 1'b0, '0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/popcount255_pipe.md
Name: popcount255_pipe

Overview:
- Registered population counter: counts the 1 bits in a 255-bit input word and returns the count as an 8-bit unsigned value.
- Two-stage pipeline: partial-sum stage, then final adder stage.
- Accepts one word per clock; a valid strobe travels alongside the data.
- Sits in datapaths that need per-word Hamming weight (e.g. parity/density checks, mask sizing).

Parameters:
- None. Input width is fixed at 255, output width at 8 (max count 255 = 8'hFF, no overflow possible).

Ports:
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies in on the current cycle
- in  input  255  word to be counted; bit 0 is LSB
- out_valid  output  1  qualifies out; asserted exactly 2 cycles after in_valid was sampled high
- out  output  8  number of 1 bits in the corresponding input word

Behaviour:
- All state updates on the rising edge of clk; no combinational path from in to out.
- Stage 1 (edge N):
  - Split in into 16 chunks: bits [16k+15:16k] for k=0..14, plus chunk 15 = bits [254:240] (15 bits).
  - Register each chunk's popcount in a 5-bit partial register (max 16).
  - Register in_valid into a stage-1 valid flag.
- Stage 2 (edge N+1):
  - Sum the 16 partials with an adder tree, zero-extended to 8 bits.
  - Register the sum into out and the stage-1 valid flag into out_valid.
- Latency is exactly 2 cycles: in/in_valid sampled at edge N appear on out/out_valid after edge N+1.
- Throughput is 1 word/cycle; back-to-back valid words produce back-to-back results in order.
- No stall/backpressure input; the downstream must accept every result.
- Data registers always load, regardless of in_valid:
  - out follows the 2-cycle-delayed count of whatever is on in.
  - out_valid marks which results are meaningful.
  - Consumers ignore out when out_valid=0.
- Reset (rst high at a rising edge):
  - All partial registers, the stage-1 valid flag, out and out_valid clear to 0 on that edge.
  - Reset has priority over loading.
  - Words in flight are discarded, never emitted.
- Reset release:
  - The first word sampled on the first edge with rst=0 appears 2 cycles later.
  - out_valid stays 0 until then.
- Boundary values: in=0 -> out=8'h00; in=all ones -> out=8'hFF; bit 254 alone -> out=8'h01. Chunk 15 must not read a nonexistent bit 255.
- No X propagation from reset: outputs are defined from the first edge with rst=1.

Test Plan:
- Reset then single words: apply rst for 2 cycles, release, present one word per cycle with in_valid=1: 255'h0, 255'h1, 255'h3, 255'h7 -> out_valid high from 2 cycles after the first word; out = 8'h00, 8'h01, 8'h02, 8'h03 in consecutive cycles.
- Pattern words, back-to-back: 255'haaaa then 255'hf0000 -> out = 8'h08 then 8'h04, exactly 2 cycles after each input, no bubble.
- Extremes and chunk boundaries:
  - all-ones -> 8'hFF.
  - Only bit 254 set -> 8'h01.
  - Bits 15 and 16 set -> 8'h02.
  - Bits 239 and 240 set -> 8'h02.
- Valid gating: alternate in_valid 1/0 with arbitrary data -> out_valid reproduces the pattern delayed 2 cycles; out values for valid slots are correct.
- Reset mid-stream: issue 3 valid words, assert rst for 1 cycle while 2 are in flight, then release with in_valid=0 -> out=0 and out_valid=0 on the edge where rst=1 is sampled. The in-flight results are never emitted: out_valid=0 until new valid input.
- Randomized soak: 1000 random 255-bit words with random in_valid -> out matches the reference bit count delayed 2 cycles on every out_valid cycle.
